// File: rtl/fofb_orbit_error_stream.sv
// Orbit-error stream: subtracts per-BPM setpoints from the link readout, saturates,
// qualifies on beam sum and forwards each FA burst to the correction DSP over AXI-stream.
module fofb_orbit_error_stream #(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int FIFO_AW          = 5,
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                        sysClk,
    input  logic                        sysReset_n,
    input  logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutIndex,
    input  logic [31:0]                 fofbDSPreadoutX,
    input  logic [31:0]                 fofbDSPreadoutY,
    input  logic [31:0]                 fofbDSPreadoutS,
    input  logic                        fofbDSPreadoutValid,
    input  logic                        spWrite,
    input  logic [FOFB_INDEX_WIDTH-1:0] spAddr,
    input  logic [31:0]                 spX,
    input  logic [31:0]                 spY,
    input  logic [31:0]                 sumThreshold,
    input  logic                        clearStatus,
    output logic                        m_TVALID,
    input  logic                        m_TREADY,
    output logic [63:0]                 m_TDATA,
    output logic [FOFB_INDEX_WIDTH:0]   m_TUSER,
    output logic                        m_TLAST,
    output logic                        overflow,
    output logic [DROP_COUNT_WIDTH-1:0] dropCount,
    output logic [15:0]                 packetCount,
    output logic [FOFB_INDEX_WIDTH:0]   lastPacketLength
);

    localparam int IW    = FOFB_INDEX_WIDTH;
    localparam int EW    = 64 + IW + 2;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]          DEPTH_V  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0]        PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]          CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [IW:0]               LEN_ONE  = (IW + 1)'(1);
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_ONE = DROP_COUNT_WIDTH'(1);

    function automatic logic [31:0] sat32(input logic signed [32:0] v);
        if (v[32] != v[31])
            return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return v[31:0];
    endfunction

    logic [63:0] spRam [2**IW];
    logic [63:0] spRdData;

    // Setpoint RAM has no reset; a same-cycle write and read returns the old word.
    always_ff @(posedge sysClk) begin
        if (spWrite)
            spRam[spAddr] <= {spX, spY};
        spRdData <= spRam[fofbDSPreadoutIndex];
    end

    logic          aValid;
    logic [31:0]   aX, aY, aS;
    logic [IW-1:0] aIdx;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            aValid <= 1'b0;
            aX     <= '0;
            aY     <= '0;
            aS     <= '0;
            aIdx   <= '0;
        end else begin
            aValid <= fofbDSPreadoutValid;
            aX     <= fofbDSPreadoutX;
            aY     <= fofbDSPreadoutY;
            aS     <= fofbDSPreadoutS;
            aIdx   <= fofbDSPreadoutIndex;
        end
    end

    logic signed [32:0] diffX, diffY;
    logic               aLowSum;

    always_comb begin
        diffX   = $signed({aX[31], aX}) - $signed({spRdData[63], spRdData[63:32]});
        diffY   = $signed({aY[31], aY}) - $signed({spRdData[31], spRdData[31:0]});
        aLowSum = (aS < sumThreshold);
    end

    logic          bValid, bLowSum;
    logic [31:0]   bErrX, bErrY;
    logic [IW-1:0] bIdx;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            bValid  <= 1'b0;
            bLowSum <= 1'b0;
            bErrX   <= '0;
            bErrY   <= '0;
            bIdx    <= '0;
        end else begin
            bValid  <= aValid;
            bLowSum <= aLowSum;
            bErrX   <= aLowSum ? 32'h0 : sat32(diffX);
            bErrY   <= aLowSum ? 32'h0 : sat32(diffY);
            bIdx    <= aIdx;
        end
    end

    // One-entry hold lets the last beat of a burst be tagged once the valid gap is seen.
    logic          hValid;
    logic [EW-2:0] hEntry;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            hValid <= 1'b0;
            hEntry <= '0;
        end else begin
            hValid <= bValid;
            if (bValid)
                hEntry <= {bErrX, bErrY, bLowSum, bIdx};
        end
    end

    logic          push, pushLast;
    logic [EW-1:0] pushData;

    always_comb begin
        push     = hValid;
        pushLast = !bValid;
        pushData = {hEntry, pushLast};
    end

    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr, rdPtr;
    logic [FIFO_AW:0]   memCount;
    logic               outValid;
    logic [EW-1:0]      outData;
    logic               pop, outFree, full, accept, drop, loadFromMem, bypass, memWrite;

    // Capacity counts the output register; an empty FIFO bypasses the memory entirely.
    always_comb begin
        pop         = outValid & m_TREADY;
        outFree     = !outValid | pop;
        full        = ((memCount + {{FIFO_AW{1'b0}}, outValid}) == DEPTH_V);
        accept      = push & (!full | pop);
        drop        = push & full & !pop;
        loadFromMem = outFree & (memCount != '0);
        bypass      = outFree & (memCount == '0) & accept;
        memWrite    = accept & !bypass;
    end

    always_ff @(posedge sysClk) begin
        if (memWrite)
            mem[wrPtr] <= pushData;
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            memCount <= '0;
            outValid <= 1'b0;
            outData  <= '0;
        end else begin
            if (memWrite)
                wrPtr <= wrPtr + PTR_ONE;
            if (loadFromMem)
                rdPtr <= rdPtr + PTR_ONE;
            if (memWrite && !loadFromMem)
                memCount <= memCount + CNT_ONE;
            else if (!memWrite && loadFromMem)
                memCount <= memCount - CNT_ONE;
            if (outFree) begin
                outValid <= loadFromMem | bypass;
                if (loadFromMem)
                    outData <= mem[rdPtr];
                else if (bypass)
                    outData <= pushData;
            end
        end
    end

    logic [IW:0] burstCount;

    // Burst length includes dropped entries so the DSP can tell a truncated frame.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            burstCount       <= '0;
            overflow         <= 1'b0;
            dropCount        <= '0;
            packetCount      <= '0;
            lastPacketLength <= '0;
        end else begin
            if (push)
                burstCount <= pushLast ? '0 : burstCount + LEN_ONE;
            if (clearStatus) begin
                overflow         <= 1'b0;
                dropCount        <= '0;
                packetCount      <= '0;
                lastPacketLength <= '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    if (dropCount != '1)
                        dropCount <= dropCount + DROP_ONE;
                end
                if (push && pushLast) begin
                    packetCount      <= packetCount + 16'd1;
                    lastPacketLength <= burstCount + LEN_ONE;
                end
            end
        end
    end

    always_comb begin
        m_TVALID = outValid;
        m_TDATA  = outData[EW-1 -: 64];
        m_TUSER  = outData[IW+1:1];
        m_TLAST  = outData[0];
    end

endmodule

// File: tb/tb_fofb_orbit_error_stream.sv
// Directed bench for fofb_orbit_error_stream: a setpoint/threshold model fills a
// scoreboard queue as entries are driven; a negedge monitor compares each output beat.
module tb_fofb_orbit_error_stream;

    localparam int IW = 9;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct packed {
        logic [63:0] data;
        logic [IW:0] user;
        logic        last;
    } beat_t;

    logic          sysClk = 1'b0;
    logic          sysReset_n;
    logic [IW-1:0] fofbDSPreadoutIndex;
    logic [31:0]   fofbDSPreadoutX, fofbDSPreadoutY, fofbDSPreadoutS;
    logic          fofbDSPreadoutValid;
    logic          spWrite;
    logic [IW-1:0] spAddr;
    logic [31:0]   spX, spY;
    logic [31:0]   sumThreshold;
    logic          clearStatus;
    logic          m_TVALID, m_TREADY, m_TLAST;
    logic [63:0]   m_TDATA;
    logic [IW:0]   m_TUSER;
    logic          overflow;
    logic [DW-1:0] dropCount;
    logic [15:0]   packetCount;
    logic [IW:0]   lastPacketLength;

    int          compareCount = 0;
    int          failCount    = 0;
    beat_t       expQ[$];
    logic [31:0] spXM [0:511];
    logic [31:0] spYM [0:511];
    logic [31:0] thr;
    logic        randomReady = 1'b0;
    logic        monitorOn   = 1'b1;
    int          expPackets  = 0;

    always #5 sysClk = ~sysClk;

    fofb_orbit_error_stream #(
        .FOFB_INDEX_WIDTH(IW),
        .FIFO_AW(AW),
        .DROP_COUNT_WIDTH(DW)
    ) dut (
        .sysClk(sysClk),
        .sysReset_n(sysReset_n),
        .fofbDSPreadoutIndex(fofbDSPreadoutIndex),
        .fofbDSPreadoutX(fofbDSPreadoutX),
        .fofbDSPreadoutY(fofbDSPreadoutY),
        .fofbDSPreadoutS(fofbDSPreadoutS),
        .fofbDSPreadoutValid(fofbDSPreadoutValid),
        .spWrite(spWrite),
        .spAddr(spAddr),
        .spX(spX),
        .spY(spY),
        .sumThreshold(sumThreshold),
        .clearStatus(clearStatus),
        .m_TVALID(m_TVALID),
        .m_TREADY(m_TREADY),
        .m_TDATA(m_TDATA),
        .m_TUSER(m_TUSER),
        .m_TLAST(m_TLAST),
        .overflow(overflow),
        .dropCount(dropCount),
        .packetCount(packetCount),
        .lastPacketLength(lastPacketLength)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] satModel(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        if (d > MAXV) return 32'h7FFF_FFFF;
        if (d < MINV) return 32'h8000_0000;
        return d[31:0];
    endfunction

    task automatic tick();
        @(posedge sysClk);
        #1;
        if (randomReady)
            m_TREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic writeSp(input int idx, input logic [31:0] x, input logic [31:0] y);
        spWrite = 1'b1;
        spAddr  = IW'(idx);
        spX     = x;
        spY     = y;
        tick();
        spWrite = 1'b0;
        spXM[idx] = x;
        spYM[idx] = y;
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] s, input logic last, input logic keep);
        beat_t b;
        logic  low;
        fofbDSPreadoutValid = 1'b1;
        fofbDSPreadoutIndex = IW'(idx);
        fofbDSPreadoutX     = x;
        fofbDSPreadoutY     = y;
        fofbDSPreadoutS     = s;
        if (keep) begin
            low    = (s < thr);
            b.data = low ? 64'h0 : {satModel(x, spXM[idx]), satModel(y, spYM[idx])};
            b.user = {low, IW'(idx)};
            b.last = last;
            expQ.push_back(b);
        end
        tick();
    endtask

    task automatic endBurst();
        fofbDSPreadoutValid = 1'b0;
        tick();
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        repeat (3) tick();
    endtask

    task automatic checkStatus(input string tag, input logic ov, input int drops, input int len);
        checkOutput({tag, ".overflow"}, overflow, ov);
        checkOutput({tag, ".dropCount"}, dropCount, drops);
        checkOutput({tag, ".packetCount"}, packetCount, expPackets);
        checkOutput({tag, ".lastPacketLength"}, lastPacketLength, len);
    endtask

    // Every valid output beat must equal the queue head; it retires only when accepted.
    always @(negedge sysClk) begin
        if (monitorOn && sysReset_n && m_TVALID) begin
            if (expQ.size() == 0)
                checkOutput("unexpectedBeat", m_TVALID, 1'b0);
            else begin
                checkOutput("beat", {m_TDATA, m_TUSER, m_TLAST}, expQ[0]);
                if (m_TREADY)
                    void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sysReset_n          = 1'b0;
        fofbDSPreadoutIndex = '0;
        fofbDSPreadoutX     = '0;
        fofbDSPreadoutY     = '0;
        fofbDSPreadoutS     = '0;
        fofbDSPreadoutValid = 1'b0;
        spWrite             = 1'b0;
        spAddr              = '0;
        spX                 = '0;
        spY                 = '0;
        thr                 = 32'd10;
        sumThreshold        = 32'd10;
        clearStatus         = 1'b0;
        m_TREADY            = 1'b1;
        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("reset.TVALID", m_TVALID, 1'b0);
        checkOutput("reset.TDATA", m_TDATA, 64'h0);
        checkOutput("reset.TUSER", m_TUSER, '0);
        checkOutput("reset.TLAST", m_TLAST, 1'b0);
        checkStatus("reset", 1'b0, 0, 0);
        sysReset_n = 1'b1;
        tick();

        for (int i = 0; i < 64; i++)
            writeSp(i, 32'(i * 1000 + 7), 32'(-(i * 13)));

        $display("[TB] setpoint subtraction and first-beat latency");
        writeSp(3, 32'd100, -32'sd50);
        applyStimulus(3, 32'd150, -32'sd40, 32'd1000, 1'b1, 1'b1);
        fofbDSPreadoutValid = 1'b0;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        checkOutput("latency.n+3", m_TVALID, 1'b0);
        @(negedge sysClk);
        checkOutput("latency.n+4", m_TVALID, 1'b1);
        tick();
        waitDrain(50);
        expPackets = 1;
        checkStatus("single", 1'b0, 0, 1);

        $display("[TB] low sum qualification");
        applyStimulus(3, 32'd150, -32'sd40, 32'd5, 1'b1, 1'b1);
        endBurst();
        waitDrain(50);
        expPackets++;

        $display("[TB] saturation");
        writeSp(0, -32'sd2, 32'd1);
        applyStimulus(0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1000, 1'b1, 1'b1);
        endBurst();
        waitDrain(50);
        expPackets++;

        $display("[TB] burst framing");
        for (int i = 0; i < 8; i++)
            applyStimulus(i, 32'(i * 77 - 300), 32'(5000 - i * 91), 32'd500, i == 7, 1'b1);
        endBurst();
        tick();
        for (int i = 8; i < 11; i++)
            applyStimulus(i, 32'(i * 1234), 32'(-i * 4321), 32'd500, i == 10, 1'b1);
        endBurst();
        waitDrain(60);
        expPackets += 2;
        checkStatus("framing", 1'b0, 0, 3);

        $display("[TB] random backpressure");
        randomReady = 1'b1;
        for (int i = 0; i < 20; i++)
            applyStimulus(20 + i, $urandom, $urandom, 32'($urandom_range(0, 40)), i == 19, 1'b1);
        endBurst();
        waitDrain(400);
        randomReady = 1'b0;
        m_TREADY    = 1'b1;
        expPackets++;
        checkStatus("backpressure", 1'b0, 0, 20);

        $display("[TB] overflow with sink stalled");
        m_TREADY = 1'b0;
        for (int i = 0; i < 40; i++)
            applyStimulus(i, $urandom, $urandom, 32'd800, i == 39, i < 32);
        endBurst();
        repeat (6) tick();
        expPackets++;
        checkStatus("overflow", 1'b1, 8, 40);
        m_TREADY = 1'b1;
        waitDrain(100);
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        expPackets  = 0;
        checkStatus("clear", 1'b0, 0, 0);

        $display("[TB] setpoint write/read collision");
        writeSp(2, 32'd1000, 32'd2000);
        spWrite = 1'b1;
        spAddr  = IW'(2);
        spX     = 32'd5000;
        spY     = 32'd6000;
        applyStimulus(2, 32'd7000, 32'd8000, 32'd1000, 1'b1, 1'b1);
        spWrite = 1'b0;
        spXM[2] = 32'd5000;
        spYM[2] = 32'd6000;
        endBurst();
        tick();
        applyStimulus(2, 32'd7000, 32'd8000, 32'd1000, 1'b1, 1'b1);
        endBurst();
        waitDrain(50);
        expPackets += 2;
        checkStatus("collision", 1'b0, 0, 1);

        $display("[TB] reset asserted and released mid-burst");
        monitorOn = 1'b0;
        m_TREADY  = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(i, 32'(i), 32'(i), 32'd900, 1'b0, 1'b0);
        checkOutput("preReset.TVALID", m_TVALID, 1'b1);
        fofbDSPreadoutIndex = IW'(6);
        #2;
        sysReset_n = 1'b0;
        #1;
        checkOutput("inReset.TVALID", m_TVALID, 1'b0);
        checkOutput("inReset.TDATA", m_TDATA, 64'h0);
        checkOutput("inReset.TLAST", m_TLAST, 1'b0);
        checkOutput("inReset.packetCount", packetCount, 16'd0);
        tick();
        for (int i = 7; i < 10; i++)
            applyStimulus(i, 32'(i), 32'(i), 32'd900, 1'b0, 1'b0);
        sysReset_n = 1'b1;
        m_TREADY   = 1'b1;
        monitorOn  = 1'b1;
        expPackets = 0;
        checkOutput("postRelease.TVALID", m_TVALID, 1'b0);
        for (int i = 10; i < 14; i++)
            applyStimulus(i, 32'(i * 3), 32'(-i * 5), 32'd900, i == 13, 1'b1);
        endBurst();
        waitDrain(60);
        expPackets = 1;
        checkStatus("afterReset", 1'b0, 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
